bram_line_arbiter: RTL

Two-port arbiter and sequencer for the line-wide backing BRAM. It sits between the instruction-cache refill port (port 0, read-only) and the data-cache refill/writeback port (port 1, read/write with byte mask). It grants one whole-line transaction at a time using round-robin arbitration. It drives the BRAM enable, read, write, address, data and mask controls, and returns one response per accepted request.

---
 rtl/bram_line_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/bram_line_arbiter.sv
// rtl/bram_line_arbiter.sv - round-robin line arbiter/sequencer for the backing BRAM (port 0 read, port 1 read/write)
// Optional read watchdog: define BRAM_ARB_TIMEOUT_EN.
module bram_line_arbiter #(
    parameter int ADDR_SIZE   = 7,
    parameter int OFFSET_BITS = 6,
    parameter int DATA_SIZE   = 2 ** (OFFSET_BITS + 3),
    parameter int WR_CYCLES   = 2,
    parameter int STALL_LIMIT = 1023
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             req0_valid,
    input  logic [ADDR_SIZE+OFFSET_BITS-1:0] req0_addr,
    output logic                             req0_ready,
    output logic                             rsp0_valid,
    output logic [DATA_SIZE-1:0]             rsp0_data,
    input  logic                             req1_valid,
    input  logic                             req1_write,
    input  logic [ADDR_SIZE+OFFSET_BITS-1:0] req1_addr,
    input  logic [DATA_SIZE-1:0]             req1_wdata,
    input  logic [DATA_SIZE-1:0]             req1_mask,
    output logic                             req1_ready,
    output logic                             rsp1_valid,
    output logic [DATA_SIZE-1:0]             rsp1_data,
    output logic                             rsp_err,
    output logic                             bram_enable,
    output logic                             read_enable,
    output logic                             write_enable,
    output logic [ADDR_SIZE+OFFSET_BITS-1:0] addr_read,
    output logic [ADDR_SIZE+OFFSET_BITS-1:0] addr_write,
    output logic [DATA_SIZE-1:0]             data_input,
    output logic [DATA_SIZE-1:0]             data_mask,
    input  logic [DATA_SIZE-1:0]             data_out,
    input  logic                             data_ready
);
    localparam int AW  = ADDR_SIZE + OFFSET_BITS;
    localparam int WCW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
    localparam logic [AW-1:0] LINE_MASK = {{ADDR_SIZE{1'b1}}, {OFFSET_BITS{1'b0}}};

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  write_q, write_d;
    logic                  last_grant_q, last_grant_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [DATA_SIZE-1:0]  wdata_q, wdata_d;
    logic [DATA_SIZE-1:0]  mask_q, mask_d;
    logic [WCW-1:0]        wr_cnt_q, wr_cnt_d;
    logic [DATA_SIZE-1:0]  rsp0_data_q, rsp0_data_d;
    logic [DATA_SIZE-1:0]  rsp1_data_q, rsp1_data_d;
    logic                  grant0, grant1;
`ifdef BRAM_ARB_TIMEOUT_EN
    localparam int TCW = $clog2(STALL_LIMIT + 1);
    logic [TCW-1:0]        to_cnt_q, to_cnt_d;
    logic                  err_q, err_d;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            write_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            mask_q       <= '0;
            wr_cnt_q     <= '0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
`ifdef BRAM_ARB_TIMEOUT_EN
            to_cnt_q     <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            write_q      <= write_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mask_q       <= mask_d;
            wr_cnt_q     <= wr_cnt_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_data_q  <= rsp1_data_d;
`ifdef BRAM_ARB_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
            err_q        <= err_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        write_d      = write_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mask_d       = mask_q;
        wr_cnt_d     = wr_cnt_q;
        rsp0_data_d  = rsp0_data_q;
        rsp1_data_d  = rsp1_data_q;
`ifdef BRAM_ARB_TIMEOUT_EN
        to_cnt_d     = to_cnt_q;
        err_d        = err_q;
`endif
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        rsp0_valid   = 1'b0;
        rsp1_valid   = 1'b0;
        rsp_err      = 1'b0;
        bram_enable  = 1'b0;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        addr_read    = '0;
        addr_write   = '0;
        data_input   = '0;
        data_mask    = '0;
        rsp0_data    = rsp0_data_q;
        rsp1_data    = rsp1_data_q;

        // Port 0 wins a tie unless it was the last one served.
        grant0 = req0_valid && (!req1_valid || last_grant_q);
        grant1 = req1_valid && !grant0;

        case (state_q)
            IDLE: begin
                // Gated by reset so ready stays low while the block is held in reset.
                if (reset && (grant0 || grant1)) begin
                    req0_ready   = grant0;
                    req1_ready   = grant1;
                    owner_d      = grant1;
                    last_grant_d = grant1;
                    write_d      = grant1 && req1_write;
                    addr_d       = grant1 ? req1_addr : req0_addr;
                    wdata_d      = req1_wdata;
                    mask_d       = req1_mask;
                    wr_cnt_d     = WCW'(WR_CYCLES - 1);
`ifdef BRAM_ARB_TIMEOUT_EN
                    to_cnt_d     = '0;
                    err_d        = 1'b0;
`endif
                    state_d      = (grant1 && req1_write) ? WRITE : READ;
                end
            end
            READ: begin
                bram_enable = 1'b1;
                read_enable = 1'b1;
                addr_read   = addr_q & LINE_MASK;
                if (data_ready) begin
                    if (owner_q) rsp1_data_d = data_out;
                    else         rsp0_data_d = data_out;
                    state_d = RESP;
                end
`ifdef BRAM_ARB_TIMEOUT_EN
                else if (to_cnt_q == TCW'(STALL_LIMIT - 1)) begin
                    if (owner_q) rsp1_data_d = '0;
                    else         rsp0_data_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    to_cnt_d = to_cnt_q + TCW'(1);
                end
`endif
            end
            WRITE: begin
                bram_enable  = 1'b1;
                write_enable = 1'b1;
                addr_write   = addr_q & LINE_MASK;
                data_input   = wdata_q;
                data_mask    = mask_q;
                if (wr_cnt_q == '0) begin
                    rsp1_data_d = '0;
                    state_d     = RESP;
                end else begin
                    wr_cnt_d = wr_cnt_q - WCW'(1);
                end
            end
            RESP: begin
                rsp0_valid = !owner_q;
                rsp1_valid = owner_q;
`ifdef BRAM_ARB_TIMEOUT_EN
                rsp_err    = err_q;
`endif
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
